// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the VGA clock timekeeping core.
//   - alarm_state_t and its state constants (OFF, ARMED, RINGING, SNOOZE)
//   - field maxima and widths for seconds / minutes / hours
package clock_pkg;

  typedef logic [1:0] alarm_state_t;

  localparam alarm_state_t ST_OFF     = 2'd0;
  localparam alarm_state_t ST_ARMED   = 2'd1;
  localparam alarm_state_t ST_RINGING = 2'd2;
  localparam alarm_state_t ST_SNOOZE  = 2'd3;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 11;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HRS_W = 4;

endpackage

// File: rtl/alarm_timekeeper_if.sv
// alarm_timekeeper_if: tick / button pulses in, time / alarm / buzzer out.
//   slave  : the timekeeper core (consumes pulses, drives time and buzzer)
//   master : the surrounding top level or bench (drives pulses, reads time)
interface alarm_timekeeper_if;
  import clock_pkg::*;

  logic             tick_1hz;
  logic             tick_buzz;
  logic             sec_adj;
  logic             min_adj;
  logic             hrs_adj;
  logic             al_adj;
  logic             al_toggle;
  logic [SEC_W-1:0] seconds;
  logic [MIN_W-1:0] minutes;
  logic [HRS_W-1:0] hours;
  logic [MIN_W-1:0] al_minutes;
  logic [HRS_W-1:0] al_hours;
  logic             al_on;
  logic             alarm_active;
  logic             buzzer_out;

  modport slave (
    input  tick_1hz, tick_buzz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle,
    output seconds, minutes, hours, al_minutes, al_hours,
           al_on, alarm_active, buzzer_out
  );

  modport master (
    output tick_1hz, tick_buzz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle,
    input  seconds, minutes, hours, al_minutes, al_hours,
           al_on, alarm_active, buzzer_out
  );

endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-(MAX+1) up-counter.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   inc_i      : advance by one this cycle
//   cnt_o      : registered count, always 0..MAX
//   carry_o    : combinational, high when inc_i wraps MAX -> 0
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         carry_o
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign carry_o = inc_i && (cnt_q == MAXV);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = (cnt_q == MAXV) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alarm_timekeeper.sv
// alarm_timekeeper: 12-hour time of day, alarm time, alarm FSM and buzzer gate.
//   clk, reset : 31.5 MHz clock, synchronous active-high reset
//   bus        : alarm_timekeeper_if.slave (tick/button pulses in; time,
//                alarm time, al_on, alarm_active, buzzer_out out)
// Build option ALARM_SNOOZE_EN: adds the SNOOZE state; an adjust pulse while
// ringing snoozes for SNOOZE_MINUTES instead of changing time/alarm.
module alarm_timekeeper
  import clock_pkg::*;
#(
  parameter int AL_MIN_STEP    = 10,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic             clk,
  input  logic             reset,
  alarm_timekeeper_if.slave bus
);

  if (AL_MIN_STEP < 1 || AL_MIN_STEP > 59) begin : g_bad_step
    $error("AL_MIN_STEP out of range 1..59");
  end
  if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59) begin : g_bad_snooze
    $error("SNOOZE_MINUTES out of range 1..59");
  end

  localparam int RW = $clog2(RING_SECONDS + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

  alarm_state_t     st_q, st_d;
  logic [RW-1:0]    ring_q, ring_d;
  logic [MIN_W-1:0] alm_q, alm_d;
  logic [HRS_W-1:0] alh_q, alh_d;
  logic             buzz_q, buzz_d;
  logic             al_on_q, active_q;
  logic             consume;

  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HRS_W-1:0] hrs;
  logic             sec_carry, min_carry, hrs_carry_unused;

  // A snoozing adjust pulse is swallowed; tick_1hz still advances time.
`ifdef ALARM_SNOOZE_EN
  logic [MIN_W-1:0] snz_q, snz_d;
  logic [MIN_W:0]   snz_sum;
  assign consume = (st_q == ST_RINGING) && !bus.al_toggle &&
                   (bus.sec_adj || bus.min_adj || bus.hrs_adj || bus.al_adj);
  assign snz_sum = {1'b0, min} + (MIN_W+1)'(SNOOZE_MINUTES);
`else
  assign consume = 1'b0;
`endif

  wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset),
    .inc_i(bus.tick_1hz || (bus.sec_adj && !consume)),
    .cnt_o(sec), .carry_o(sec_carry));

  wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset),
    .inc_i(sec_carry || (bus.min_adj && !consume)),
    .cnt_o(min), .carry_o(min_carry));

  // Hours roll 11 -> 0 with nothing above them.
  wrap_counter #(.W(HRS_W), .MAX(HRS_MAX)) u_hrs (
    .clk(clk), .reset(reset),
    .inc_i(min_carry || (bus.hrs_adj && !consume)),
    .cnt_o(hrs), .carry_o(hrs_carry_unused));

  // Alarm time: step minutes, fold overflow into hours.
  logic [MIN_W:0] al_sum;
  always_comb begin
    alm_d  = alm_q;
    alh_d  = alh_q;
    al_sum = {1'b0, alm_q} + (MIN_W+1)'(AL_MIN_STEP);
    if (bus.al_adj && !consume) begin
      if (al_sum >= (MIN_W+1)'(60)) begin
        alm_d = MIN_W'(al_sum - (MIN_W+1)'(60));
        alh_d = (alh_q == HRS_W'(HRS_MAX)) ? '0 : alh_q + 1'b1;
      end else begin
        alm_d = al_sum[MIN_W-1:0];
      end
    end
  end

  // Match uses registered time, so RINGING lands two cycles after the tick.
  logic match;
  assign match = (hrs == alh_q) && (min == alm_q) && (sec == '0);

  always_comb begin
    st_d   = st_q;
    ring_d = ring_q;
`ifdef ALARM_SNOOZE_EN
    snz_d  = snz_q;
`endif
    case (st_q)
      ST_OFF:   if (bus.al_toggle) st_d = ST_ARMED;
      ST_ARMED: begin
        if (bus.al_toggle) st_d = ST_OFF;
        else if (match) begin
          st_d   = ST_RINGING;
          ring_d = '0;
        end
      end
      ST_RINGING: begin
        if (bus.al_toggle) st_d = ST_OFF;
`ifdef ALARM_SNOOZE_EN
        else if (consume) begin
          st_d  = ST_SNOOZE;
          snz_d = (snz_sum >= (MIN_W+1)'(60)) ? MIN_W'(snz_sum - (MIN_W+1)'(60))
                                              : snz_sum[MIN_W-1:0];
        end
`endif
        else if (bus.tick_1hz) begin
          if (ring_q == RING_LAST) begin
            st_d   = ST_ARMED;
            ring_d = '0;
          end else begin
            ring_d = ring_q + 1'b1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (bus.al_toggle) st_d = ST_OFF;
        else if (min == snz_q && sec == '0) begin
          st_d   = ST_RINGING;
          ring_d = '0;
        end
      end
`endif
      default: st_d = ST_OFF;
    endcase
  end

  // Tone toggles only during even seconds of ringing; otherwise held low.
  always_comb begin
    buzz_d = 1'b0;
    if (st_q == ST_RINGING && !sec[0]) buzz_d = bus.tick_buzz ? !buzz_q : buzz_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_OFF;
      ring_q   <= '0;
      alm_q    <= '0;
      alh_q    <= '0;
      buzz_q   <= 1'b0;
      al_on_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      ring_q   <= ring_d;
      alm_q    <= alm_d;
      alh_q    <= alh_d;
      buzz_q   <= buzz_d;
      al_on_q  <= (st_d != ST_OFF);
      active_q <= (st_d == ST_RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (reset) snz_q <= '0;
    else       snz_q <= snz_d;
  end
`endif

  assign bus.seconds      = sec;
  assign bus.minutes      = min;
  assign bus.hours        = hrs;
  assign bus.al_minutes   = alm_q;
  assign bus.al_hours     = alh_q;
  assign bus.al_on        = al_on_q;
  assign bus.alarm_active = active_q;
  assign bus.buzzer_out   = buzz_q;

endmodule
